// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch queue.
//   fetch_entry_t : {pc, instr} pair as stored in the fetch FIFO
//   PC_STEP       : byte stride between sequential fetches
//   ptr_width()   : FIFO pointer width for a given depth
package fetch_pkg;
  localparam int FETCH_PC_W  = 9;
  localparam int FETCH_INS_W = 32;
  localparam int PC_STEP     = 4;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]  pc;
    logic [FETCH_INS_W-1:0] instr;
  } fetch_entry_t;

  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush.
// Ports:
//   clk, reset   : clock, async active-low reset
//   flush        : drop all contents (wins over push/pop)
//   push, wdata  : write wdata at the tail
//   pop          : drop head entry (ignored when empty)
//   count        : number of stored entries (0..DEPTH)
//   head         : head entry, all-zero when empty
import fetch_pkg::*;

module fetch_fifo #(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = 4,
  localparam int PW      = ptr_width(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  entry_t       wdata,
  input  logic         pop,
  output logic [PW:0]  count,
  output entry_t       head
);
  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

  // The issuer's credit scheme must never let a write land on a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !flush && (count == (PW+1)'(DEPTH))));
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between a 1-cycle-latency instruction memory
// and the IF/ID register. Issues sequential fetches under a credit limit,
// buffers returned {pc, instr} pairs, flushes and restarts on redirect.
// Ports:
//   clk, reset            : clock, async active-low reset
//   redirect, redirect_pc : flush and restart fetch at redirect_pc
//   halt                  : stop issuing (in-flight word still lands)
//   imem_en, imem_addr    : memory read request
//   imem_rdata            : read data, valid the cycle after the request
//   out_valid/out_ready   : head handshake toward the core
//   out_pc, out_instr     : head entry, zero when not valid
// Optional feature macro: FETCH_QUEUE_BYPASS_EN -- when the FIFO is empty a
// returning word is presented combinationally and skips the FIFO if taken.
import fetch_pkg::*;

module fetch_queue #(
  parameter int PC_W     = 9,
  parameter int INS_W    = 32,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic             halt,
  output logic             imem_en,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [INS_W-1:0] out_instr
);
  localparam int PW = ptr_width(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] instr;
  } entry_t;

  logic [PC_W-1:0] fetch_pc, rsp_pc, fetch_pc_nxt;
  logic            rsp_valid;
  logic [PW:0]     count;
  logic [PW+1:0]   credits_used;
  logic            credit_ok, push, pop, bypass;
  entry_t          rsp_entry, head;

  // Words in the FIFO plus the word on the memory bus; a same-cycle pop
  // deliberately does not return a credit.
  assign credits_used = (PW+2)'(count) + (PW+2)'(rsp_valid);
  assign credit_ok    = credits_used < (PW+2)'(DEPTH);

  // Redirect re-issues at the target regardless of credits since the
  // queue is flushed at the same edge. Reset gates the request off.
  always_comb begin
    imem_addr = fetch_pc;
    imem_en   = 1'b0;
    if (reset) begin
      if (redirect) begin
        imem_addr = redirect_pc;
        imem_en   = !halt;
      end else begin
        imem_en   = !halt && credit_ok;
      end
    end
  end

  always_comb begin
    fetch_pc_nxt = fetch_pc;
    if (redirect)     fetch_pc_nxt = halt ? redirect_pc : redirect_pc + PC_W'(PC_STEP);
    else if (imem_en) fetch_pc_nxt = fetch_pc + PC_W'(PC_STEP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc  <= PC_W'(RESET_PC);
      rsp_valid <= 1'b0;
      rsp_pc    <= '0;
    end else begin
      fetch_pc  <= fetch_pc_nxt;
      rsp_valid <= imem_en;
      rsp_pc    <= imem_addr;
    end
  end

  assign rsp_entry = '{pc: rsp_pc, instr: imem_rdata};

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = (count == '0) && rsp_valid && !redirect;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that the core takes this cycle never enters the FIFO.
  assign push = rsp_valid && !redirect && !(bypass && out_ready);
  assign pop  = out_ready && (count != '0);

  fetch_fifo #(.entry_t(entry_t), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (push),
    .wdata (rsp_entry),
    .pop   (pop),
    .count (count),
    .head  (head)
  );

  assign out_valid = (count != '0) || bypass;
  assign out_pc    = bypass ? rsp_entry.pc    : head.pc;
  assign out_instr = bypass ? rsp_entry.instr : head.instr;
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  logic        clk = 0;
  logic        reset = 0;
  logic        redirect = 0;
  logic [8:0]  redirect_pc = '0;
  logic        halt = 0;
  logic        imem_en;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [8:0]  out_pc;
  logic [31:0] out_instr;

  int n_checks = 0;
  int n_errors = 0;

  fetch_queue #(.PC_W(9), .INS_W(32), .DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed hash of the address.
  function automatic logic [31:0] mem_f(input logic [8:0] a);
    return 32'hC0DE0000 ^ ({23'd0, a} * 32'h9E3779B1);
  endfunction

  // Synchronous memory with 1-cycle read latency.
  always @(posedge clk) if (imem_en) imem_rdata <= mem_f(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference stream: delivered words are consecutive PCs (mod 512) from
  // the last reset/redirect target, each carrying mem_f(pc).
  logic [8:0] exp_q[$];
  int idle = 0;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete(); exp_q.push_back(9'd0); idle = 0;
    end else if (redirect) begin
      exp_q.delete(); exp_q.push_back(redirect_pc); idle = 0;
    end else if (out_valid && out_ready) begin
      chk("out_pc", {23'd0, out_pc}, {23'd0, exp_q[0]});
      chk("out_instr", out_instr, mem_f(exp_q[0]));
      exp_q.push_back(exp_q[0] + 9'd4);
      void'(exp_q.pop_front());
      idle = 0;
    end else begin
      if (!out_valid) begin
        chk("idle_zero", {out_pc, out_instr[22:0]} | {23'd0, out_instr[31:23]}, 32'd0);
      end
      if (out_ready && !halt) idle++; else idle = 0;
      if (idle > 20) begin
        chk("liveness", 32'd0, 32'd1);
        idle = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reset pulse; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    reset = 0; #1;
    chk("rst_en", {31'd0, imem_en}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc", {23'd0, out_pc}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_addr", {23'd0, imem_addr}, 32'd0);
    tick(); tick();
    reset = 1;
  endtask

  initial begin
    // Test 1: reset release with ready high, address sequence and latency.
    out_ready = 1;
    tick();
    do_reset(); #1;
    chk("t1_addr0", {23'd0, imem_addr}, 32'd0);
    chk("t1_en0", {31'd0, imem_en}, 32'd1);
    tick();
    chk("t1_addr1", {23'd0, imem_addr}, 32'd4);
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("t1_valid_n1", {31'd0, out_valid}, 32'd1);
`else
    chk("t1_valid_n1", {31'd0, out_valid}, 32'd0);
`endif
    tick();
    chk("t1_addr2", {23'd0, imem_addr}, 32'd8);
    chk("t1_valid_n2", {31'd0, out_valid}, 32'd1);
    tick();
    chk("t1_addr3", {23'd0, imem_addr}, 32'd12);
    repeat (6) tick();

    // Test 2: core stalls, queue saturates, then drains in order.
    out_ready = 0;
    do_reset();
    repeat (10) tick();
    chk("t2_en", {31'd0, imem_en}, 32'd0);
    chk("t2_addr", {23'd0, imem_addr}, 32'd16);
    chk("t2_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_head", {23'd0, out_pc}, 32'd0);
    out_ready = 1;
    repeat (8) tick();

    // Test 3 / 6: three queued, one in flight; redirect flushes.
    out_ready = 0;
    do_reset();
    repeat (4) tick();
    chk("t3_en_pre", {31'd0, imem_en}, 32'd0);
    // Mid-operation reset clears outputs asynchronously.
    do_reset();
    repeat (4) tick();
    redirect = 1; redirect_pc = 9'h040; #1;
    chk("t3_addr", {23'd0, imem_addr}, 32'h40);
    chk("t3_en", {31'd0, imem_en}, 32'd1);
    tick();
    redirect = 0; #1;
`ifdef FETCH_QUEUE_BYPASS_EN
    chk("t3_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_pc", {23'd0, out_pc}, 32'h40);
`else
    chk("t3_valid", {31'd0, out_valid}, 32'd0);
`endif
    chk("t3_addr2", {23'd0, imem_addr}, 32'h44);
    out_ready = 1;
    repeat (8) tick();

    // Test 4: halt with one request in flight.
    do_reset();
    tick();
    halt = 1; #1;
    repeat (3) begin
      chk("t4_en", {31'd0, imem_en}, 32'd0);
      chk("t4_addr", {23'd0, imem_addr}, 32'd4);
      tick();
    end
    halt = 0; #1;
    chk("t4_resume_en", {31'd0, imem_en}, 32'd1);
    chk("t4_resume_addr", {23'd0, imem_addr}, 32'd4);
    repeat (6) tick();

    // Test 5: PC wraps modulo 512.
    redirect = 1; redirect_pc = 9'h1F8;
    tick();
    redirect = 0; #1;
    chk("t5_addr1", {23'd0, imem_addr}, 32'h1FC);
    tick();
    chk("t5_addr2", {23'd0, imem_addr}, 32'h000);
    repeat (8) tick();

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      halt        = ($urandom_range(0, 15) == 0);
      redirect    = ($urandom_range(0, 31) == 0);
      redirect_pc = 9'($urandom) & 9'h1FC;
      if ($urandom_range(0, 999) == 0) begin
        redirect = 0; halt = 0;
        do_reset();
      end
      tick();
    end
    redirect = 0; halt = 0; out_ready = 1;
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction prefetch queue between the synchronous instruction memory and the IF/ID pipeline register. It generates sequential fetch addresses and issues reads to a memory with 1-cycle read latency. Returned {pc, instr} pairs are buffered in a small FIFO, so the core can stall (hazard stall or halt) without losing fetched words. A branch or jump redirect (the EX-stage PcSel/BrPC pair) flushes the queue and restarts fetch at the target.

Parameters:
PC_W, 9, PC / instruction-memory byte-address width
INS_W, 32, instruction width
DEPTH, 4, FIFO entries; power of two, minimum 2; full throughput requires DEPTH >= 3
RESET_PC, 0, first fetch address after reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
redirect  input  1  flush queue and restart fetch (driven by PcSel)
redirect_pc  input  PC_W  restart address (BrPC[PC_W-1:0])
halt  input  1  stop issuing new fetches
imem_en  output  1  read request this cycle
imem_addr  output  PC_W  read address
imem_rdata  input  INS_W  read data, valid the cycle after the request
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts head entry (!stall && !halt)
out_pc  output  PC_W  PC of head entry
out_instr  output  INS_W  instruction of head entry

Behaviour:
- Reset (reset=0, asynchronous): fetch_pc=RESET_PC, count=0, rd/wr pointers=0, rsp_valid=0. Outputs: imem_en=0, out_valid=0, out_pc=0, out_instr=0, imem_addr=RESET_PC. First request is issued in the first cycle after reset deasserts. Reset asserted mid-operation discards all queued and in-flight words.
- Issue: imem_en=1 when !halt && (count + rsp_valid) < DEPTH. A pop in the same cycle does not free a credit. imem_addr=fetch_pc. On issue, fetch_pc <= fetch_pc+4, modulo 2^PC_W (508 -> 0 for PC_W=9). rsp_valid <= imem_en; rsp_pc <= imem_addr.
- Response: when rsp_valid=1, {rsp_pc, imem_rdata} is written at the tail at the end of that cycle. The credit rule guarantees the FIFO is never full at write time. An overflow is an assertion failure.
- Output: out_valid = (count != 0). out_pc and out_instr come from the head entry. Pop happens on out_valid && out_ready. When not valid, out_pc and out_instr are 0.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pop while empty has no effect.
- Latency without bypass: request in cycle N -> data on imem_rdata in N+1 -> out_valid in N+2.
- Redirect, highest priority: at the edge, count=0, pointers reset, and any in-flight response is dropped (rsp_valid <= 0 unless re-issued). In the redirect cycle itself: imem_addr=redirect_pc, imem_en=!halt, fetch_pc <= redirect_pc+4 (or redirect_pc if halted). out_valid is not gated combinationally; the consumer flushes. A pop in a redirect cycle is discarded by the flush.
- Halt: no new issues and fetch_pc is frozen. An in-flight response still completes into the FIFO. Queued entries are held.
- Redirect and halt together: queue flushed, fetch_pc <= redirect_pc, no issue.

Optional Feature:
FETCH_QUEUE_BYPASS_EN
- Defined: when count==0 and rsp_valid=1 and redirect=0, the response drives out_valid, out_pc and out_instr combinationally. If out_ready=1, the word is not written to the FIFO. Latency drops to N+1.
- Undefined: all words pass through the FIFO; latency is N+2.

Decomposition:
- Package fetch_pkg holds: typedef fetch_entry_t {logic [PC_W-1:0] pc; logic [INS_W-1:0] instr;}, localparam PC_STEP=4, and function ptr_width(DEPTH).
- Sub-module fetch_fifo: a parameterised synchronous FIFO of fetch_entry_t with flush, push, pop, count and head outputs. Issue, credit and redirect logic stay in fetch_queue.

Test Plan:
1. Reset release, out_ready=1 -> imem_addr sequence 0,4,8,12. First out_valid 2 cycles after the first issue with out_pc=0, then one entry per cycle (pc 4, 8, ...).
2. out_ready=0 for 10 cycles -> count saturates at 4, imem_en=0 with fetch_pc=16. Release -> entries pc 0,4,8,12 drain in order, then fetch resumes at 16.
3. redirect=1, redirect_pc=0x40 with 3 queued entries and one in flight -> next cycle count=0 and the in-flight word is not enqueued. First out_pc=0x40, followed by 0x44.
4. halt=1 with one request in flight -> that word is enqueued, imem_en stays 0 and fetch_pc is held. Clear halt -> issue resumes at the held address.
5. fetch_pc=0x1FC with PC_W=9 -> next imem_addr=0x000, with out_pc order 0x1FC, 0x000.
6. reset asserted while count=3 -> all outputs zero immediately, without a clock edge. With FETCH_QUEUE_BYPASS_EN defined, the first out_valid appears 1 cycle after the first issue.
